uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling at CLKS_PER_BIT rx_clk cycles per bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       rx_clk,
    input  logic       rx_rst,
    input  logic       rx_serial,
    output logic [7:0] rx_data_out,
    output logic       rx_data_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START_BIT  = 3'd1,
        RX_DATA_BIT   = 3'd2,
        RX_PARITY_BIT = 3'd3,
        RX_STOP_BIT   = 3'd4,
        RX_CLEANUP    = 3'd5,
        RX_WAIT_HIGH  = 3'd6
    } rx_state_t;

    rx_state_t  state, state_next;
    logic       rx_meta, rx_s;
    logic [7:0] cnt, cnt_next;
    logic [2:0] idx, idx_next;
    logic [7:0] shift, shift_next;
    logic [7:0] data_next;
    logic       valid_next, ferr_next;
    logic [1:0] flush;
    logic       armed, armed_next;
`ifdef UART_RX_PARITY_EN
    logic       par_bit, par_next;
    logic       perr_next;
`endif

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state         <= RX_IDLE;
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            rx_data_out   <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            flush         <= '0;
            armed         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_meta       <= rx_serial;
            rx_s          <= rx_meta;
            state         <= state_next;
            cnt           <= cnt_next;
            idx           <= idx_next;
            shift         <= shift_next;
            rx_data_out   <= data_next;
            rx_data_valid <= valid_next;
            rx_frame_err  <= ferr_next;
            flush         <= {flush[0], 1'b1};
            armed         <= armed_next;
`ifdef UART_RX_PARITY_EN
            par_bit       <= par_next;
            rx_parity_err <= perr_next;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    // After reset the line must be seen high (once the synchronizer has flushed its
    // reset value) before a start bit is accepted, so an interrupted frame's tail is ignored.
    assign armed_next = armed | (flush[1] & rx_s);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        data_next  = rx_data_out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_bit;
        perr_next  = 1'b0;
`endif
        case (state)
            RX_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (!rx_s && armed) state_next = RX_START_BIT;
            end
            RX_START_BIT: begin
                if (cnt == HALF_BIT) begin
                    cnt_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA_BIT;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            RX_DATA_BIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_s;
                    if (idx == 3'd7) begin
                        idx_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY_BIT;
`else
                        state_next = RX_STOP_BIT;
`endif
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY_BIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    par_next   = rx_s;
                    state_next = RX_STOP_BIT;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
`endif
            RX_STOP_BIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = ^{shift, par_bit};
`endif
                        state_next = RX_CLEANUP;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            RX_CLEANUP:   state_next = RX_IDLE;
            RX_WAIT_HIGH: if (rx_s) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 87 clocks/bit: framing, glitch rejection, break, back-to-back, reset abort, parity.
module tb_uart_rx;

    localparam int CPB = 87;

    logic       rx_clk = 1'b0;
    logic       rx_rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;

    always #5 rx_clk = ~rx_clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .rx_clk       (rx_clk),
        .rx_rst       (rx_rst),
        .rx_serial    (rx_serial),
        .rx_data_out  (rx_data_out),
        .rx_data_valid(rx_data_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err)
    );

    int cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    // Pulse monitor: running totals, sampled on the falling edge
    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_vp = 0, n_vf = 0, n_long = 0;
    int         valid_cyc [64];
    logic [7:0] valid_data [64];
    logic       pv = 1'b0, pf = 1'b0, pp = 1'b0;

    always @(negedge rx_clk) begin
        if (rx_data_valid) begin
            if (n_valid < 64) begin
                valid_cyc[n_valid]  = cyc;
                valid_data[n_valid] = rx_data_out;
            end
            n_valid++;
        end
        if (rx_frame_err) n_ferr++;
        if (rx_parity_err) n_perr++;
        if (rx_data_valid && rx_parity_err) n_vp++;
        if (rx_data_valid && rx_frame_err) n_vf++;
        if ((rx_data_valid && pv) || (rx_frame_err && pf) || (rx_parity_err && pp)) n_long++;
        pv = rx_data_valid;
        pf = rx_frame_err;
        pp = rx_parity_err;
    end

    int vectors = 0, miscompares = 0;
    int fall_cyc = 0;
    int bv, bf, bp, bvp, lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rx_clk);
    endtask

    task automatic drive_bit(input logic b, input logic rst_here);
        rx_serial = b;
        if (rst_here) begin
            idle(20);
            rx_rst = 1'b1;
            idle(3);
            rx_rst = 1'b0;
            idle(CPB - 23);
        end else begin
            idle(CPB);
        end
    endtask

    // rst_bit selects the data bit during which rx_rst is pulsed (-1: none)
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int rst_bit);
        fall_cyc = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], rst_bit == i);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, 1'b0);
`else
        if (par !== par) rx_serial = 1'b1;
`endif
        drive_bit(stop, 1'b0);
    endtask

    task automatic snap();
        bv  = n_valid;
        bf  = n_ferr;
        bp  = n_perr;
        bvp = n_vp;
    endtask

    initial begin
        // Reset state
        rx_rst = 1'b1;
        idle(5);
        chk("reset_data", rx_data_out, 8'h00);
        chk("reset_valid", rx_data_valid, 1'b0);
        chk("reset_ferr", rx_frame_err, 1'b0);
        chk("reset_perr", rx_parity_err, 1'b0);
        rx_rst = 1'b0;
        idle(10);

        // 0xA5 framing and latency from line fall
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(100);
        lat = valid_cyc[bv] - fall_cyc;
        chk("a5_count", n_valid - bv, 1);
        chk("a5_latency_826_832", (lat >= 826 && lat <= 832), 1);
        chk("a5_data", rx_data_out, 8'hA5);
        chk("a5_ferr", n_ferr - bf, 0);
        chk("a5_perr", n_perr - bp, 0);

        // 20-cycle glitch rejected, next frame received
        snap();
        rx_serial = 1'b0;
        idle(20);
        rx_serial = 1'b1;
        idle(150);
        chk("glitch_valid", n_valid - bv, 0);
        chk("glitch_ferr", n_ferr - bf, 0);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        idle(100);
        chk("after_glitch_count", n_valid - bv, 1);
        chk("after_glitch_data", rx_data_out, 8'h3C);

        // Stop bit low followed by a long break
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(2000);
        chk("break_ferr", n_ferr - bf, 1);
        chk("break_valid", n_valid - bv, 0);
        chk("break_data_kept", rx_data_out, 8'h3C);
        rx_serial = 1'b1;
        idle(100);
        chk("break_release_ferr", n_ferr - bf, 1);
        send_frame(8'h96, 1'b0, 1'b1, -1);
        idle(100);
        chk("after_break_count", n_valid - bv, 1);
        chk("after_break_data", rx_data_out, 8'h96);

        // Back-to-back frames, single stop bit
        snap();
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        idle(100);
        chk("b2b_count", n_valid - bv, 2);
        chk("b2b_data0", valid_data[bv], 8'h00);
        chk("b2b_data1", valid_data[bv + 1], 8'hFF);
        chk("b2b_spacing", valid_cyc[bv + 1] - valid_cyc[bv], 870);

        // Reset pulsed during data bit 4
        snap();
        send_frame(8'h81, 1'b1, 1'b1, 4);
        idle(300);
        chk("rst_abort_valid", n_valid - bv, 0);
        chk("rst_abort_ferr", n_ferr - bf, 0);
        chk("rst_abort_perr", n_perr - bp, 0);
        chk("rst_abort_data", rx_data_out, 8'h00);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(100);
        chk("after_rst_count", n_valid - bv, 1);
        chk("after_rst_data", rx_data_out, 8'h5A);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(100);
        chk("par_ok_valid", n_valid - bv, 1);
        chk("par_ok_perr", n_perr - bp, 0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1, -1);
        idle(100);
        chk("par_bad_valid", n_valid - bv, 1);
        chk("par_bad_perr", n_perr - bp, 1);
        chk("par_bad_together", n_vp - bvp, 1);
        chk("par_bad_data", rx_data_out, 8'h07);
`else
        chk("perr_tied_low_total", n_perr, 0);
        chk("perr_tied_low_now", rx_parity_err, 1'b0);
`endif

        chk("valid_ferr_overlap", n_vf, 0);
        chk("pulse_width_one", n_long, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
